// File: rtl/seg_display_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display.
// Segment codes are active-low with bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  // Blink half-period: ON shows the display, OFF forces it dark.
  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  // One registered display word: anodes, cathodes, decimal point.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

  // Active-low one-cold anode select for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   nibble_i  4-bit digit value (0-9 decimal, 10-15 shown as a dash)
//   seg_o     7-bit active-low pattern {g,f,e,d,c,b,a}
module bcd_to_seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: the default arm assigns seg_o on every path, so no latch is inferred.
    unique case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit stopwatch display (MM.SS).
// A prescaler sets the per-digit dwell time; a frame-aligned snapshot of Q
// keeps each frame tear-free; leading-zero blanking and whole-display
// blinking are applied in the registered output stage.
// Ports:
//   clk_in    sole clock, rising edge
//   RESET_N   synchronous active-low reset
//   Q         BCD time: [4:1] sec units .. [16:13] min tens
//   BLANK_LZ  blank min-tens digit when it is zero
//   BLINK     flash the whole display
//   AN        active-low anodes, AN[k] drives the digit of Q[4k:4k-3]
//   SEG       active-low cathodes {g,f,e,d,c,b,a}
//   DP        active-low decimal point, lit as the min/sec separator
module seg_scan_driver
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk_in,
  input  logic        RESET_N,
  input  logic [16:1] Q,
  input  logic        BLANK_LZ,
  input  logic        BLINK,
  output logic [4:1]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_DP   = IDX_W'(2);

  logic [PRE_W-1:0]            presc_q, presc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]  snap_q, snap_d;
  logic [FRM_W-1:0]            frame_q, frame_d;
  blink_phase_e                phase_q, phase_d;
  disp_t                       disp_q, disp_d;

  logic       tick;
  logic       frame_wrap;
  logic       lz_blank;
  logic       blink_blank;
  logic [3:0] nibble;
  logic [6:0] nibble_seg;

  assign tick       = (presc_q == PRE_LAST);
  assign frame_wrap = tick && (idx_q == IDX_LAST);

  // The decoded digit always comes from the snapshot, never live Q.
  assign nibble      = snap_q[idx_q];
  assign lz_blank    = BLANK_LZ && (idx_q == IDX_LAST) && (snap_q[NUM_DIGITS-1] == 4'd0);
  assign blink_blank = BLINK && (phase_q == PHASE_OFF);

  bcd_to_seg u_bcd_to_seg (
    .nibble_i (nibble),
    .seg_o    (nibble_seg)
  );

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    // Four digits fill the index width exactly, so 3 -> 0 wraps naturally.
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
    snap_d  = frame_wrap ? Q : snap_q;

    frame_d = frame_q;
    phase_d = phase_q;
    if (!BLINK) begin
      frame_d = '0;
      phase_d = PHASE_ON;
    end else if (frame_wrap) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Either blanking source simply forces the whole word dark.
    if (lz_blank || blink_blank) begin
      disp_d = DISP_OFF;
    end else begin
      disp_d = '{an: an_select(idx_q), seg: nibble_seg, dp: (idx_q != IDX_DP)};
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RESET_N) begin
      presc_q <= '0;
      idx_q   <= '0;
      // NOTE: the snapshot is reset on purpose: the first post-reset frame
      // must display zeros rather than stale or unknown digits.
      snap_q  <= '0;
      frame_q <= '0;
      phase_q <= PHASE_ON;
      disp_q  <= DISP_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign AN  = disp_q.an;
  assign SEG = disp_q.seg;
  assign DP  = disp_q.dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRAME_CYC = 4 * DIV;
  localparam logic [11:0] ALL_OFF = {4'b1111, 7'b1111111, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] q;
  logic        blz;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk_in   (clk),
    .RESET_N  (rst_n),
    .Q        (q),
    .BLANK_LZ (blz),
    .BLINK    (blink),
    .AN       (an),
    .SEG      (seg),
    .DP       (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got an/seg/dp=%b_%b_%b want %b_%b_%b", name,
               got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: time is an absolute count of clock edges since reset.
  // Slot = edges / DIV, digit = slot mod 4, a new frame starts every 16 edges;
  // blink phase = (frames seen with BLINK held high / BF) mod 2.
  int          m_edges = 0;
  int          m_wraps = 0;
  int          m_idx;
  logic [15:0] m_snap  = '0;
  logic        m_valid = 1'b0;
  logic        m_off;
  logic [3:0]  m_nib;
  logic [3:0]  m_an;
  logic [11:0] m_exp;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_exp   = ALL_OFF;
      m_edges = 0;
      m_wraps = 0;
      m_snap  = '0;
      m_valid = 1'b1;
    end else begin
      m_idx = (m_edges / DIV) % 4;
      m_nib = m_snap[m_idx*4 +: 4];
      m_off = (blink && ((m_wraps / BF) % 2 == 1)) || (blz && m_idx == 3 && m_nib == 4'd0);
      m_an  = ~(4'b0001 << m_idx);
      m_exp = m_off ? ALL_OFF : {m_an, seg_ref(m_nib), (m_idx != 2)};
      m_edges++;
      if (m_edges % FRAME_CYC == 0) begin
        m_snap  = q;
        m_wraps = blink ? m_wraps + 1 : 0;
      end else if (!blink) begin
        m_wraps = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) check("model", {an, seg, dp}, m_exp);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until just after a frame-wrap edge (snapshot just loaded).
  task automatic goto_frame_start();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_edges > 0 && m_edges % FRAME_CYC == 0) && n < 3 * FRAME_CYC);
    if (n >= 3 * FRAME_CYC) begin
      total++;
      bad++;
      $display("FAIL frame_align: no frame boundary within %0d cycles", n);
    end
  endtask

  typedef struct packed {
    logic [15:0]      q;
    logic             blz;
    logic [3:0][3:0]  an;
    logic [3:0][6:0]  seg;
    logic [3:0]       dp;
  } vec_t;

  vec_t tv[6];

  initial begin
    // Slot order inside the packed fields is {slot3, slot2, slot1, slot0}.
    tv[0] = '{q: 16'h1234, blz: 1'b0,
              an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dp: 4'b1011};
    tv[1] = '{q: 16'h0930, blz: 1'b1,
              an: {4'b1111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b1111111, 7'b0010000, 7'b0110000, 7'b1000000}, dp: 4'b1011};
    tv[2] = '{q: 16'h0930, blz: 1'b0,
              an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b1000000, 7'b0010000, 7'b0110000, 7'b1000000}, dp: 4'b1011};
    tv[3] = '{q: 16'h00A0, blz: 1'b0,
              an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, dp: 4'b1011};
    tv[4] = '{q: 16'h5678, blz: 1'b1,
              an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, dp: 4'b1011};
    tv[5] = '{q: 16'hFB0C, blz: 1'b1,
              an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              seg: {7'b0111111, 7'b0111111, 7'b1000000, 7'b0111111}, dp: 4'b1011};

    rst_n = 1'b0;
    q     = 16'h1234;
    blz   = 1'b0;
    blink = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Mid-frame reset, then check slot timing and the zero snapshot.
    repeat (23) step();
    rst_n = 1'b0;
    step();
    check("reset_off", {an, seg, dp}, ALL_OFF);
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      case (n)
        1:  check("post_reset_idx0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        4:  check("slot0_last",      {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        5:  check("idx1_at_4",       {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
        9:  check("idx2_at_8",       {an, seg, dp}, {4'b1011, 7'b1000000, 1'b0});
        13: check("idx3_at_12",      {an, seg, dp}, {4'b0111, 7'b1000000, 1'b1});
        17: check("idx0_at_16",      {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        default: ;
      endcase
    end

    // Table-driven frame checks: every cycle of every slot.
    for (int v = 0; v < 6; v++) begin
      q   = tv[v].q;
      blz = tv[v].blz;
      goto_frame_start();
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < DIV; c++) begin
          step();
          check($sformatf("vec%0d_slot%0d", v, k), {an, seg, dp},
                {tv[v].an[k], tv[v].seg[k], tv[v].dp[k]});
        end
      end
    end

    // Tearing: Q changes while digit 1 is on screen.
    q   = 16'h1234;
    blz = 1'b0;
    goto_frame_start();
    goto_frame_start();
    for (int e = 1; e <= 2 * FRAME_CYC; e++) begin
      step();
      if (e == 5) q = 16'h5959;
      case (e)
        9:  check("tear_slot2_old", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b0});
        13: check("tear_slot3_old", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        17: check("tear_new_s0",    {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});
        21: check("tear_new_s1",    {an, seg, dp}, {4'b1101, 7'b0010010, 1'b1});
        25: check("tear_new_s2",    {an, seg, dp}, {4'b1011, 7'b0010000, 1'b0});
        29: check("tear_new_s3",    {an, seg, dp}, {4'b0111, 7'b0010010, 1'b1});
        default: ;
      endcase
    end

    // Blink: two frames visible, two dark, repeating; release shows at once.
    q = 16'h1234;
    goto_frame_start();
    blink = 1'b1;
    for (int f = 0; f < 6; f++) begin
      step();
      check($sformatf("blink_frame%0d", f), {an, seg, dp},
            ((f % 4) >= 2) ? ALL_OFF : {4'b1110, 7'b0011001, 1'b1});
      repeat (FRAME_CYC - 1) step();
    end
    step();
    check("blink_frame6_off", {an, seg, dp}, ALL_OFF);
    repeat (5) step();
    blink = 1'b0;
    step();
    check("blink_release", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});

    // Randomized traffic against the reference model.
    blink = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        q = 16'($urandom);
        if ($urandom_range(0, 1) == 1) q[15:12] = 4'd0;
      end
      if ($urandom_range(0, 20) == 0)  blz   = ~blz;
      if ($urandom_range(0, 150) == 0) blink = ~blink;
      rst_n = ($urandom_range(0, 400) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk_in cycles per digit slot; legal range ≥2.
REQ-002 Parameter BLINK_FRAMES, default 32, full scan frames per blink half-period; legal range ≥1.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 RESET_N  input  1  synchronous, active-low reset.
REQ-005 Q  input  16  BCD time from stopwatch: [4:1] sec units, [8:5] sec tens, [12:9] min units, [16:13] min tens.
REQ-006 BLANK_LZ  input  1  1 = blank min-tens digit when it is 0.
REQ-007 BLINK  input  1  1 = flash whole display (paused/force-stopped indication).
REQ-008 AN  output  4  active-low digit anodes; AN[k] drives digit holding Q[4k:4k-3].
REQ-009 SEG  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-010 DP  output  1  active-low decimal point, used as min/sec separator.

Function
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = prescaler at REFRESH_DIV-1.
REQ-012 Digit index idx (0..3) SHALL advance by 1 on each tick, wrapping 3→0; one frame = 4 slots.
REQ-013 Snapshot register SHALL load Q on the tick where idx wraps 3→0; all digits of a frame SHALL come from one snapshot (no tearing).
REQ-014 AN, SEG, DP SHALL be registered, decoded from current idx and snapshot; outputs reflect a new idx exactly 1 cycle after idx changes.
REQ-015 Selected slot: AN bit idx+1 = 0, others 1; SEG = active-low pattern of snapshot nibble idx.
REQ-016 Digits 0-9 SHALL use standard patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-017 Nibble values 10-15 SHALL display dash 0111111.
REQ-018 BLANK_LZ=1 and snapshot[16:13]=0 during idx=3: AN=1111, SEG=1111111, DP=1.
REQ-019 DP SHALL be 0 only while idx=2 slot is displayed and not blanked; else 1.
REQ-020 Frame counter SHALL count completed frames 0..BLINK_FRAMES-1 and toggle blink phase on wrap.
REQ-021 BLINK=0 SHALL hold frame counter and phase at 0; display always on.
REQ-022 BLINK=1 with phase=1 SHALL force AN=1111, SEG=1111111, DP=1; scan and snapshot continue unchanged.
REQ-023 Slot with blanking and BLINK-off coinciding: outputs all-off (no priority conflict).

Reset
REQ-024 RESET_N=0 at a clock edge SHALL clear prescaler, idx, snapshot, frame counter, phase; next-cycle outputs AN=1111, SEG=1111111, DP=1.
REQ-025 Reset SHALL take effect mid-frame with no partial-slot completion; first post-reset cycle decodes idx=0 from snapshot 0.

Structure
REQ-026 Package seg_display_pkg SHALL hold digit count (4), segment pattern constants, DASH and OFF codes.
REQ-027 Combinational sub-module bcd_to_seg SHALL map a 4-bit nibble to 7-bit active-low pattern (REQ-016/017).

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset: RESET_N low 2 cycles mid-frame -> AN=1111, SEG=1111111, DP=1 next cycle; after release idx advances at cycles 4, 8, 12, 16.
REQ-029 Q=16'h1234, BLANK_LZ=0, after one frame boundary -> AN 1110/1101/1011/0111 with SEG 0011001/0110000/0100100/1111001; DP=0 only with AN=1011.
REQ-030 Tearing: Q changes 16'h1234→16'h5959 during idx=1 -> remaining slots show 2,1; next frame shows 9,5,9,5.
REQ-031 Q=16'h0930: BLANK_LZ=1 -> idx=3 slot AN=1111; BLANK_LZ=0 -> AN=0111, SEG=1000000.
REQ-032 Q=16'h00A0 -> sec-tens slot SEG=0111111; other digits 0.
REQ-033 BLINK=1 -> frames 0-1 visible, 2-3 all-off, repeating; BLINK→0 -> visible from next registered output.
